// File: rtl/dec_loop_counter_pkg.sv
// Shared state encoding for loop and schedule controllers.
package dec_loop_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } loop_state_t;

endpackage

// File: rtl/dec_loop_counter_dec.sv
// DEC datapath component: unsigned decrement by one.
module dec_loop_counter_dec #(
  parameter int DATAWIDTH = 2
) (
  input  logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] y
);

  assign y = a - DATAWIDTH'(1);

endmodule

// File: rtl/dec_loop_counter.sv
// Loop-iteration controller: counts a loaded budget down through DEC,
// ticking once per executed iteration and pulsing Done on exhaustion.
//
// state | meaning
// IDLE  | waiting for Start; Count holds its last value
// RUN   | one iteration per non-Hold cycle; Abort returns to IDLE
// DONE  | single-cycle completion pulse, then back to IDLE
module dec_loop_counter
  import dec_loop_counter_pkg::*;
#(
  parameter int DATAWIDTH = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [DATAWIDTH-1:0] Load,
  input  logic                 Hold,
  input  logic                 Abort,
  output logic                 Busy,
  output logic                 Tick,
  output logic                 Done,
  output logic [DATAWIDTH-1:0] Count
);

  loop_state_t          state;
  logic [DATAWIDTH-1:0] count_q;
  logic [DATAWIDTH-1:0] count_dec;

  dec_loop_counter_dec #(
    .DATAWIDTH(DATAWIDTH)
  ) u_dec (
    .a(count_q),
    .y(count_dec)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            count_q <= Load;
            state   <= (Load == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Abort wins over Hold and over the final decrement; Count freezes.
          if (Abort) begin
            state <= IDLE;
          end else if (!Hold) begin
            if (count_q == DATAWIDTH'(1)) begin
              count_q <= '0;
              state   <= DONE;
            end else begin
              count_q <= count_dec;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Busy  = (state == RUN);
  assign Tick  = (state == RUN) && !Hold;
  assign Done  = (state == DONE);
  assign Count = count_q;

endmodule

// File: tb/tb_dec_loop_counter.sv
// Directed self-checking bench for dec_loop_counter at widths 2 and 8.
module tb_dec_loop_counter;

  logic       clk;
  logic       rst2, start2, hold2, abort2;
  logic [1:0] load2;
  logic       busy2, tick2, done2;
  logic [1:0] count2;

  logic       rst8, start8, hold8, abort8;
  logic [7:0] load8;
  logic       busy8, tick8, done8;
  logic [7:0] count8;

  int checks = 0;
  int passed = 0;
  int ticks2 = 0, dones2 = 0, ticks8 = 0, dones8 = 0;
  int t0, d0;

  dec_loop_counter #(.DATAWIDTH(2)) u_dut2 (
    .Clk(clk), .Rst(rst2), .Start(start2), .Load(load2), .Hold(hold2),
    .Abort(abort2), .Busy(busy2), .Tick(tick2), .Done(done2), .Count(count2)
  );

  dec_loop_counter #(.DATAWIDTH(8)) u_dut8 (
    .Clk(clk), .Rst(rst8), .Start(start8), .Load(load8), .Hold(hold8),
    .Abort(abort8), .Busy(busy8), .Tick(tick8), .Done(done8), .Count(count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick2 === 1'b1) ticks2++;
    if (done2 === 1'b1) dones2++;
    if (tick8 === 1'b1) ticks8++;
    if (done8 === 1'b1) dones8++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Checks the narrow instance's outputs for the current cycle.
  task automatic out2(input string tag, input int b, input int t, input int d, input int c);
    #2;
    chk({tag, ".busy"}, int'(busy2), b);
    chk({tag, ".tick"}, int'(tick2), t);
    chk({tag, ".done"}, int'(done2), d);
    chk({tag, ".count"}, int'(count2), c);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst2 = 1; start2 = 1; load2 = 2'd3; hold2 = 0; abort2 = 0;
    rst8 = 1; start8 = 0; load8 = 8'd0; hold8 = 0; abort8 = 0;

    // Reset overrides Start for two cycles.
    nxt(); nxt();
    out2("rst", 0, 0, 0, 0);
    rst2 = 0; rst8 = 0;
    nxt();
    start2 = 0;
    t0 = ticks2;
    out2("basic_c1", 1, 1, 0, 3);
    nxt(); out2("basic_c2", 1, 1, 0, 2);
    nxt(); out2("basic_c3", 1, 1, 0, 1);
    nxt(); out2("basic_done", 0, 0, 1, 0);
    nxt(); out2("basic_idle", 0, 0, 0, 0);
    chk("basic_ticks", ticks2 - t0, 3);

    // Zero-iteration loop.
    t0 = ticks2;
    start2 = 1; load2 = 2'd0;
    nxt(); start2 = 0;
    out2("zero_done", 0, 0, 1, 0);
    nxt(); out2("zero_idle", 0, 0, 0, 0);
    chk("zero_ticks", ticks2 - t0, 0);

    // Hold in the second RUN cycle.
    t0 = ticks2;
    start2 = 1; load2 = 2'd3;
    nxt(); start2 = 0;
    out2("hold_c1", 1, 1, 0, 3);
    nxt(); hold2 = 1;
    out2("hold_c2", 1, 0, 0, 2);
    nxt(); hold2 = 0;
    out2("hold_c3", 1, 1, 0, 2);
    nxt(); out2("hold_c4", 1, 1, 0, 1);
    nxt(); out2("hold_done", 0, 0, 1, 0);
    nxt(); out2("hold_idle", 0, 0, 0, 0);
    chk("hold_ticks", ticks2 - t0, 3);

    // Abort on the final iteration: Count frozen, no Done.
    d0 = dones2;
    start2 = 1; load2 = 2'd3;
    nxt(); start2 = 0;
    out2("abort_c1", 1, 1, 0, 3);
    nxt(); out2("abort_c2", 1, 1, 0, 2);
    nxt(); abort2 = 1; hold2 = 1;
    out2("abort_c3", 1, 0, 0, 1);
    nxt(); abort2 = 0; hold2 = 0;
    out2("abort_idle", 0, 0, 0, 1);
    nxt(); out2("abort_idle2", 0, 0, 0, 1);
    chk("abort_dones", dones2 - d0, 0);
    start2 = 1; load2 = 2'd2;
    nxt(); start2 = 0;
    out2("after_abort_c1", 1, 1, 0, 2);
    nxt(); out2("after_abort_c2", 1, 1, 0, 1);
    nxt(); out2("after_abort_done", 0, 0, 1, 0);
    nxt();

    // Reset mid-RUN, then the maximal loop.
    d0 = dones2;
    start2 = 1; load2 = 2'd3;
    nxt(); start2 = 0;
    out2("rstrun_c1", 1, 1, 0, 3);
    nxt(); rst2 = 1;
    nxt(); rst2 = 0;
    out2("rstrun_idle", 0, 0, 0, 0);
    nxt(); out2("rstrun_idle2", 0, 0, 0, 0);
    chk("rstrun_dones", dones2 - d0, 0);
    t0 = ticks2;
    start2 = 1; load2 = 2'd3;
    nxt(); start2 = 0;
    out2("max_c1", 1, 1, 0, 3);
    nxt(); out2("max_c2", 1, 1, 0, 2);
    nxt(); out2("max_c3", 1, 1, 0, 1);
    nxt(); out2("max_done", 0, 0, 1, 0);
    nxt(); out2("max_idle", 0, 0, 0, 0);
    chk("max_ticks", ticks2 - t0, 3);

    // Wide instance: Load=200 with Start held high throughout.
    t0 = ticks8; d0 = dones8;
    start8 = 1; load8 = 8'd200;
    nxt();
    for (int i = 0; i < 200; i++) begin
      #2;
      chk("w8_count", int'(count8), 200 - i);
      if (i != 199) nxt();
    end
    nxt(); #2;
    chk("w8_done", int'(done8), 1);
    chk("w8_done_count", int'(count8), 0);
    chk("w8_ticks", ticks8 - t0, 200);
    nxt(); #2;
    chk("w8_idle_busy", int'(busy8), 0);
    chk("w8_idle_done", int'(done8), 0);
    nxt(); #2;
    start8 = 0;
    chk("w8_restart_busy", int'(busy8), 1);
    chk("w8_restart_count", int'(count8), 200);
    chk("w8_dones", dones8 - d0, 1);
    rst8 = 1;
    nxt(); rst8 = 0;
    #2;
    chk("w8_rst_count", int'(count8), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
